apb_master_bridge: RTL and testbench

//  Bridge back end: accepts 41-bit request packets from the AHB-side front end (H_Valid/Bridge_Ready),

---
 rtl/bridge_pkg.sv | 23 ++
 rtl/bridge_pkt_fifo.sv | 61 ++++++
 rtl/apb_master_bridge.sv | 137 +++++++++++++
 tb/tb_apb_master_bridge.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: packet layout and back-end FSM encoding.
// Also used by the AHB-side front end, so field positions must not move.
package bridge_pkg;

  localparam int PKT_W         = 41;
  localparam int PKT_WRITE_BIT = 40;
  localparam int PKT_DATA_MSB  = 39;
  localparam int PKT_DATA_LSB  = 8;
  localparam int PKT_ADDR_MSB  = 7;
  localparam int PKT_ADDR_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  function automatic logic [PKT_W-1:0] pkt_pack(input logic wr, input logic [31:0] data,
                                                 input logic [7:0] addr);
    return {wr, data, addr};
  endfunction

endpackage

// File: rtl/bridge_pkt_fifo.sv
// Synchronous request-packet FIFO. Pointers wrap naturally; count carries one extra bit so
// that full and empty can be told apart. A push while full is dropped.
module bridge_pkt_fifo
  import bridge_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = PKT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 master back end: queues request packets and runs each as a SETUP->ACCESS transfer.
// Build option APB_TIMEOUT_EN adds an ACCESS watchdog and the Bridge_Timeout output.
module apb_master_bridge
  import bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
`ifdef APB_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
`endif
) (
  input  logic             HCLK,
  input  logic             RESET,
  input  logic [PKT_W-1:0] Packet_In,
  input  logic             H_Valid,
  output logic             Bridge_Ready,
  output logic [31:0]      Bridge_Rd_Data,
  output logic             Bridge_Rd_Valid,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [7:0]       PADDR,
  output logic [31:0]      PWDATA,
  input  logic [31:0]      PRDATA,
  input  logic             PREADY
`ifdef APB_TIMEOUT_EN
  ,
  output logic             Bridge_Timeout
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PKT_W-1:0] fifo_head;
  logic             push;
  logic             pop;
  logic             done;

  assign Bridge_Ready = !fifo_full;
  assign push         = H_Valid && !fifo_full;
  assign pop          = !fifo_empty && ((state == ST_IDLE) || done);

  bridge_pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PKT_W)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .din   (Packet_In),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;

  // Down-counter reaches zero in the last permitted ACCESS cycle; PREADY there still wins.
  assign tmo_hit = (state == ST_ACCESS) && (tmo_cnt == '0) && !PREADY;
  assign done    = (state == ST_ACCESS) && (PREADY || tmo_hit);

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      tmo_cnt        <= '0;
      Bridge_Timeout <= 1'b0;
    end else begin
      Bridge_Timeout <= tmo_hit;
      if (state_nxt == ST_SETUP) begin
        tmo_cnt <= TMO_LOAD;
      end else if ((state == ST_ACCESS) && (tmo_cnt != '0)) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
    end
  end
`else
  assign done = (state == ST_ACCESS) && PREADY;
`endif

  always_ff @(posedge HCLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (done) state_nxt = fifo_empty ? ST_IDLE : ST_SETUP;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    PSEL    = (state != ST_IDLE);
    PENABLE = (state == ST_ACCESS);
  end

  // Address/data are only reloaded on a pop, so they hold from SETUP through ACCESS end.
  always_ff @(posedge HCLK) begin
    if (RESET) begin
      PADDR           <= '0;
      PWRITE          <= 1'b0;
      PWDATA          <= '0;
      Bridge_Rd_Data  <= '0;
      Bridge_Rd_Valid <= 1'b0;
    end else begin
      Bridge_Rd_Valid <= 1'b0;
      if (pop) begin
        PADDR  <= fifo_head[PKT_ADDR_MSB:PKT_ADDR_LSB];
        PWRITE <= fifo_head[PKT_WRITE_BIT];
        PWDATA <= fifo_head[PKT_DATA_MSB:PKT_DATA_LSB];
      end
      if (done && !PWRITE) begin
`ifdef APB_TIMEOUT_EN
        Bridge_Rd_Data <= PREADY ? PRDATA : TIMEOUT_RDATA;
`else
        Bridge_Rd_Data <= PRDATA;
`endif
        Bridge_Rd_Valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: expected APB transfers and read results are queued
// by the stimulus and checked by negedge monitors. Define APB_TIMEOUT_EN to exercise the watchdog.
module tb_apb_master_bridge;
  import bridge_pkg::*;

  logic             HCLK = 1'b0;
  logic             RESET = 1'b1;
  logic [PKT_W-1:0] Packet_In = '0;
  logic             H_Valid = 1'b0;
  logic             Bridge_Ready;
  logic [31:0]      Bridge_Rd_Data;
  logic             Bridge_Rd_Valid;
  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [7:0]       PADDR;
  logic [31:0]      PWDATA;
  logic [31:0]      PRDATA = '0;
  logic             PREADY = 1'b0;
`ifdef APB_TIMEOUT_EN
  logic             Bridge_Timeout;
`endif

  int total = 0;
  int bad = 0;
  logic [PKT_W-1:0] apb_q[$];
  logic [31:0]      rd_q[$];
  logic             prev_setup = 1'b0;
  logic [PKT_W-1:0] prev_sig = '0;
  logic [PKT_W-1:0] exp_pkt;
  logic [31:0]      exp_rd;

  always #5 HCLK = ~HCLK;

  apb_master_bridge dut (
    .HCLK            (HCLK),
    .RESET           (RESET),
    .Packet_In       (Packet_In),
    .H_Valid         (H_Valid),
    .Bridge_Ready    (Bridge_Ready),
    .Bridge_Rd_Data  (Bridge_Rd_Data),
    .Bridge_Rd_Valid (Bridge_Rd_Valid),
    .PSEL            (PSEL),
    .PENABLE         (PENABLE),
    .PWRITE          (PWRITE),
    .PADDR           (PADDR),
    .PWDATA          (PWDATA),
    .PRDATA          (PRDATA),
    .PREADY          (PREADY)
`ifdef APB_TIMEOUT_EN
    ,
    .Bridge_Timeout  (Bridge_Timeout)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none/in-bound", name);
  endtask

  // Scoreboard monitors
  always @(negedge HCLK) begin
    if (RESET) begin
      prev_setup = 1'b0;
    end else begin
      if (PSEL && PENABLE && PREADY) begin
        if (apb_q.size() == 0) fail_now("apb_unexpected_xfer");
        else begin
          exp_pkt = apb_q.pop_front();
          check("apb_xfer", {PWRITE, PWDATA, PADDR}, exp_pkt);
        end
      end
      if (Bridge_Rd_Valid) begin
        if (rd_q.size() == 0) fail_now("rd_unexpected_valid");
        else begin
          exp_rd = rd_q.pop_front();
          check("rd_data", Bridge_Rd_Data, exp_rd);
        end
      end
      if (prev_setup) begin
        check("setup_to_access", {PSEL, PENABLE, PWRITE, PWDATA, PADDR}, {2'b11, prev_sig});
      end
      prev_setup = PSEL && !PENABLE;
      prev_sig   = {PWRITE, PWDATA, PADDR};
    end
  end

  // Caller must be just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [PKT_W-1:0] p);
    logic r;
    int   n;
    r = 1'b0;
    n = 0;
    Packet_In = p;
    H_Valid   = 1'b1;
    do begin
      @(negedge HCLK);
      r = Bridge_Ready;
      @(posedge HCLK);
      n++;
    end while (!r && n < 50);
    if (!r) fail_now("push_timeout");
    #1 H_Valid = 1'b0;
  endtask

  task automatic wait_access(input string name);
    int n;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!(PSEL && PENABLE) && n < 20);
    check(name, {PSEL, PENABLE}, 2'b11);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] pat [6];
    int         cnt;
    pat = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00};

    // reset state
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_ctrl", {PSEL, PENABLE, Bridge_Rd_Valid, Bridge_Ready}, 4'b0001);
    check("rst_rd_data", Bridge_Rd_Data, 32'h0);
    check("rst_apb_bus", {PWRITE, PWDATA, PADDR}, 41'h0);
    @(posedge HCLK);
    #1 RESET = 1'b0;

    // write, zero wait states
    PREADY = 1'b1;
    apb_q.push_back(pkt_pack(1'b1, 32'h1234_5678, 8'h10));
    push(pkt_pack(1'b1, 32'h1234_5678, 8'h10));
    @(negedge HCLK); check("t1_idle", PSEL, 1'b0);
    @(negedge HCLK); check("t1_setup", {PSEL, PENABLE, PWRITE, PADDR}, {3'b101, 8'h10});
    @(negedge HCLK); check("t1_access", {PSEL, PENABLE}, 2'b11);
    @(negedge HCLK); check("t1_done", {PSEL, PENABLE, Bridge_Rd_Valid}, 3'b000);
    @(posedge HCLK); #1 PREADY = 1'b0;

    // read with three wait states
    PRDATA = 32'hCAFE_F00D;
    rd_q.push_back(32'hCAFE_F00D);
    apb_q.push_back(pkt_pack(1'b0, 32'h0, 8'h20));
    push(pkt_pack(1'b0, 32'h0, 8'h20));
    wait_access("t2_access");
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    @(posedge HCLK); #1 PREADY = 1'b1;
    @(posedge HCLK); #1 PREADY = 1'b0;
    @(negedge HCLK);
    check("t2_rd_valid", {Bridge_Rd_Valid, PSEL}, 2'b10);
    @(negedge HCLK);
    check("t2_pulse_end", Bridge_Rd_Valid, 1'b0);
    check("t2_rd_hold", Bridge_Rd_Data, 32'hCAFE_F00D);

    // fill FIFO behind a stalled transfer, then drain back-to-back
    @(posedge HCLK); #1;
    PRDATA = 32'h1111_2222;
    apb_q.push_back(pkt_pack(1'b1, 32'hAAAA_0001, 8'h30));
    apb_q.push_back(pkt_pack(1'b0, 32'hBBBB_0002, 8'h31));
    apb_q.push_back(pkt_pack(1'b1, 32'hCCCC_0003, 8'h32));
    rd_q.push_back(32'h1111_2222);
    push(pkt_pack(1'b1, 32'hAAAA_0001, 8'h30));
    push(pkt_pack(1'b0, 32'hBBBB_0002, 8'h31));
    push(pkt_pack(1'b1, 32'hCCCC_0003, 8'h32));
    @(negedge HCLK); check("t3_full", Bridge_Ready, 1'b0);
    @(negedge HCLK); check("t3_full_hold", {Bridge_Ready, PSEL, PENABLE}, 3'b011);
    @(posedge HCLK); #1 PREADY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      check($sformatf("t3_drain_%0d", i), {PSEL, PENABLE}, pat[i]);
      if (i == 1) check("t3_ready_again", Bridge_Ready, 1'b1);
    end
    @(posedge HCLK); #1 PREADY = 1'b0;

    // reset in the middle of a read ACCESS with another packet queued
    PRDATA = 32'h4444_4444;
    push(pkt_pack(1'b0, 32'h0, 8'h40));
    push(pkt_pack(1'b1, 32'h77, 8'h41));
    wait_access("t4_access");
    @(posedge HCLK); #1 RESET = 1'b1;
    @(posedge HCLK); #1 RESET = 1'b0;
    @(negedge HCLK);
    check("t4_rst_apb", {PSEL, PENABLE, Bridge_Ready, Bridge_Rd_Valid}, 4'b0010);
    check("t4_rst_rd_data", Bridge_Rd_Data, 32'h0);
    cnt = 0;
    repeat (4) begin
      @(negedge HCLK);
      if (!PSEL && !Bridge_Rd_Valid) cnt++;
    end
    check("t4_flushed", cnt, 4);
    @(posedge HCLK); #1;

`ifdef APB_TIMEOUT_EN
    // stuck slave: abort after 16 ACCESS cycles
    PRDATA = 32'h5555_AAAA;
    rd_q.push_back(32'hDEAD_BEEF);
    push(pkt_pack(1'b0, 32'h0, 8'h60));
    wait_access("t5_access");
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge HCLK);
      if (Bridge_Timeout) break;
      if (PSEL && PENABLE) cnt++;
    end
    check("t5_timeout_cycles", cnt, 16);
    check("t5_timeout_abort", {Bridge_Timeout, PSEL, PENABLE, Bridge_Rd_Valid}, 4'b1001);
    @(negedge HCLK);
    check("t5_timeout_pulse", Bridge_Timeout, 1'b0);
`else
    // stuck slave: ACCESS must hold indefinitely
    PRDATA = 32'h5555_AAAA;
    push(pkt_pack(1'b0, 32'h99, 8'h50));
    wait_access("t5_access");
    cnt = 0;
    repeat (100) begin
      @(negedge HCLK);
      if (PSEL && PENABLE && !PWRITE && PADDR == 8'h50 && PWDATA == 32'h99 && !Bridge_Rd_Valid)
        cnt++;
    end
    check("t5_stall_100", cnt, 100);
    rd_q.push_back(32'h5555_AAAA);
    apb_q.push_back(pkt_pack(1'b0, 32'h99, 8'h50));
    @(posedge HCLK); #1 PREADY = 1'b1;
    @(posedge HCLK); #1 PREADY = 1'b0;
    @(negedge HCLK);
    check("t5_release", {Bridge_Rd_Valid, Bridge_Rd_Data}, {1'b1, 32'h5555_AAAA});
`endif

    repeat (3) @(negedge HCLK);
    check("rd_q_drained", rd_q.size(), 0);
    check("apb_q_drained", apb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
